checksum_engine_arbiter: RTL and testbench
==========================================

// Module: checksum_engine_arbiter
// PURPOSE
//  Shares one TCP checksum offload engine (cmd + req AXIS in, resp AXIS out) between NUM_REQ requesters.
//  Example requesters: TX segment builder, checksum self-test generator.
//  Grants whole packets round-robin: cmd beat, then data beats through tlast. Engine output is routed back
//  to the owning requester through an in-order tag FIFO. Sits between requesters and the engine in the frontend.
// PARAMETERS
//  NUM_REQ      2              number of requesters (2..8)
//  DATA_WIDTH   64             AXIS data width, bits
//  KEEP_WIDTH   DATA_WIDTH/8   tkeep width
//  TAG_DEPTH    4              outstanding packets tracked (power of 2, >=2)
// PORTS
//  clk                  in   1               clock
//  rst                  in   1               synchronous, active-high reset
//  src_cmd_valid        in   NUM_REQ         per-requester cmd valid
//  src_cmd_ready        out  NUM_REQ         per-requester cmd ready
//  src_cmd_csum_enable  in   NUM_REQ         packed cmd fields, requester i at slice i
//  src_cmd_csum_start   in   8*NUM_REQ       ""
//  src_cmd_csum_offset  in   8*NUM_REQ       ""
//  src_cmd_csum_init    in   16*NUM_REQ      ""
//  src_tdata            in   DATA_WIDTH*NUM_REQ  per-requester packet data
//  src_tkeep            in   KEEP_WIDTH*NUM_REQ
//  src_tvalid/src_tlast in   NUM_REQ each
//  src_tready           out  NUM_REQ
//  eng_cmd_{csum_enable,csum_start,csum_offset,csum_init,valid}  out  1/8/8/16/1  to engine
//  eng_cmd_ready        in   1
//  eng_tdata/tkeep/tvalid/tlast  out  DATA_WIDTH/KEEP_WIDTH/1/1  to engine
//  eng_tready           in   1
//  eng_resp_tdata/tkeep/tvalid/tlast  in  DATA_WIDTH/KEEP_WIDTH/1/1  from engine
//  eng_resp_tready      out  1
//  dst_tdata/tkeep/tlast  out  DATA_WIDTH/KEEP_WIDTH/1  broadcast copy of eng_resp_*
//  dst_tvalid           out  NUM_REQ         one-hot valid for owning requester
//  dst_tready           in   NUM_REQ
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, tag FIFO empty; all valid/ready outputs 0; data outputs 0.
//  - FSM IDLE: if tag FIFO not full and any src_cmd_valid, register grant = first set index at/after rr_ptr
//    (modulo NUM_REQ) -> CMD. Outputs all 0. Grant latency = 1 cycle.
//  - FSM CMD: eng_cmd_* = src_cmd_*[grant] combinationally; src_cmd_ready[grant] = eng_cmd_ready.
//    On handshake: push grant into tag FIFO, -> DATA.
//  - FSM DATA: eng_t* = src_t*[grant]; src_tready[grant] = eng_tready.
//    On tvalid&tready&tlast: rr_ptr = grant+1 (wrap at NUM_REQ), -> IDLE.
//  - Non-granted src_cmd_ready/src_tready held 0. Requester deasserting cmd_valid in CMD is illegal (no recovery).
//  - Response path independent of FSM: when FIFO non-empty, dst_tvalid[head] = eng_resp_tvalid;
//    eng_resp_tready = dst_tready[head]. FIFO empty -> eng_resp_tready=0, dst_tvalid=0.
//  - Pop head on eng_resp handshake with tlast. Push and pop in the same cycle allowed; count unchanged.
//  - Full FIFO blocks new grants only; an in-flight packet always completes.
//  - Single-beat packet (tlast on first beat) legal: DATA lasts 1 cycle.
//  - Min packet turnaround per grant: IDLE+CMD+beats cycles (no IDLE bypass).
//  - rst mid-packet: FSM and FIFO cleared the next cycle; partial engine packet is discarded by the system reset.
// CONFIGURATION
//  CSUM_ARB_STATS_EN defined: adds output stat_pkt_count [16*NUM_REQ], one counter per requester.
//    Counter increments on that requester's eng tlast handshake; wraps 0xFFFF->0; cleared by rst.
//  Not defined: port and counters absent; all other behaviour identical.
// TESTING
//  1. Req0 sends cmd(offset=26) + 6-beat pkt, req1 idle -> eng sees cmd then 6 beats in order; resp routed to dst_tvalid[0] only.
//  2. Both cmd_valid from reset -> grants req0, req1, req0, req1 (rr_ptr alternates); no beat interleaving within a packet.
//  3. eng_tready toggles 1/0 each cycle during req1 pkt -> no beat dropped or duplicated; src_tready[0] stays 0 throughout.
//  4. dst_tready held 0 with 4 packets granted -> FIFO full, 5th cmd not granted; release dst_tready -> responses to owners in grant order.
//  5. Single-beat packets back-to-back from req1 -> each pkt takes 3 cycles minimum; tag pushes equal pops.
//  6. rst asserted mid-DATA beat 3 -> next cycle all valids/readys 0, FIFO empty; with CSUM_ARB_STATS_EN, counts read 0.

Source files
------------

// File: rtl/checksum_engine_arbiter_if.sv
// Bundle of every requester, engine and response-path signal around the checksum engine arbiter.
// Ports: src_cmd_* / src_t* (requester -> arbiter), eng_cmd_* / eng_t* (arbiter -> engine),
//        eng_resp_* (engine -> arbiter), dst_* (arbiter -> requesters). master = arbiter side, slave = environment side.
interface checksum_engine_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    // requester command and packet streams, requester i at slice i
    logic [NUM_REQ-1:0]            src_cmd_valid;
    logic [NUM_REQ-1:0]            src_cmd_ready;
    logic [NUM_REQ-1:0]            src_cmd_csum_enable;
    logic [8*NUM_REQ-1:0]          src_cmd_csum_start;
    logic [8*NUM_REQ-1:0]          src_cmd_csum_offset;
    logic [16*NUM_REQ-1:0]         src_cmd_csum_init;
    logic [DATA_WIDTH*NUM_REQ-1:0] src_tdata;
    logic [KEEP_WIDTH*NUM_REQ-1:0] src_tkeep;
    logic [NUM_REQ-1:0]            src_tvalid;
    logic [NUM_REQ-1:0]            src_tlast;
    logic [NUM_REQ-1:0]            src_tready;

    // engine command and packet streams
    logic                          eng_cmd_csum_enable;
    logic [7:0]                    eng_cmd_csum_start;
    logic [7:0]                    eng_cmd_csum_offset;
    logic [15:0]                   eng_cmd_csum_init;
    logic                          eng_cmd_valid;
    logic                          eng_cmd_ready;
    logic [DATA_WIDTH-1:0]         eng_tdata;
    logic [KEEP_WIDTH-1:0]         eng_tkeep;
    logic                          eng_tvalid;
    logic                          eng_tlast;
    logic                          eng_tready;

    // engine response stream and its routed copy
    logic [DATA_WIDTH-1:0]         eng_resp_tdata;
    logic [KEEP_WIDTH-1:0]         eng_resp_tkeep;
    logic                          eng_resp_tvalid;
    logic                          eng_resp_tlast;
    logic                          eng_resp_tready;
    logic [DATA_WIDTH-1:0]         dst_tdata;
    logic [KEEP_WIDTH-1:0]         dst_tkeep;
    logic                          dst_tlast;
    logic [NUM_REQ-1:0]            dst_tvalid;
    logic [NUM_REQ-1:0]            dst_tready;

    modport master (
        input  src_cmd_valid, src_cmd_csum_enable, src_cmd_csum_start, src_cmd_csum_offset,
               src_cmd_csum_init, src_tdata, src_tkeep, src_tvalid, src_tlast,
               eng_cmd_ready, eng_tready,
               eng_resp_tdata, eng_resp_tkeep, eng_resp_tvalid, eng_resp_tlast, dst_tready,
        output src_cmd_ready, src_tready,
               eng_cmd_csum_enable, eng_cmd_csum_start, eng_cmd_csum_offset, eng_cmd_csum_init,
               eng_cmd_valid, eng_tdata, eng_tkeep, eng_tvalid, eng_tlast,
               eng_resp_tready, dst_tdata, dst_tkeep, dst_tlast, dst_tvalid
    );

    modport slave (
        output src_cmd_valid, src_cmd_csum_enable, src_cmd_csum_start, src_cmd_csum_offset,
               src_cmd_csum_init, src_tdata, src_tkeep, src_tvalid, src_tlast,
               eng_cmd_ready, eng_tready,
               eng_resp_tdata, eng_resp_tkeep, eng_resp_tvalid, eng_resp_tlast, dst_tready,
        input  src_cmd_ready, src_tready,
               eng_cmd_csum_enable, eng_cmd_csum_start, eng_cmd_csum_offset, eng_cmd_csum_init,
               eng_cmd_valid, eng_tdata, eng_tkeep, eng_tvalid, eng_tlast,
               eng_resp_tready, dst_tdata, dst_tkeep, dst_tlast, dst_tvalid
    );
endinterface

// File: rtl/checksum_engine_arbiter.sv
// Shares one TCP checksum engine among NUM_REQ requesters: whole packets (cmd beat + data through tlast)
// granted round-robin; engine responses routed back to the owner through an in-order tag FIFO.
// Latency: grant 1 cycle after cmd_valid seen in IDLE; cmd/data/resp paths are combinational pass-through.
// Backpressure: engine ready is steered to the granted requester only; a full tag FIFO blocks new grants;
// response ready comes from the owning requester's dst_tready.
// Ports: clk, rst (synchronous, active-high), bus (checksum_engine_arbiter_if.master).
// Optional: define CSUM_ARB_STATS_EN to add stat_pkt_count[16*NUM_REQ] (per-requester packet counters).
module checksum_engine_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    checksum_engine_arbiter_if.master bus
`ifdef CSUM_ARB_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]     stat_pkt_count
`endif
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] pick;
    logic          pick_vld;

    logic [GW-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [GW-1:0] head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          data_last;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(TAG_DEPTH));
    assign head       = tag_mem[rd_ptr];

    // First requesting index at or after rr_ptr; scanning downward lets the nearest one win.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.src_cmd_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick     = GW'((int'(rr_ptr) + k) % NUM_REQ);
                pick_vld = 1'b1;
            end
        end
    end

    // Request-side steering: only the granted requester sees engine ready.
    always_comb begin
        bus.eng_cmd_valid       = 1'b0;
        bus.eng_cmd_csum_enable = 1'b0;
        bus.eng_cmd_csum_start  = '0;
        bus.eng_cmd_csum_offset = '0;
        bus.eng_cmd_csum_init   = '0;
        bus.eng_tdata           = '0;
        bus.eng_tkeep           = '0;
        bus.eng_tvalid          = 1'b0;
        bus.eng_tlast           = 1'b0;
        bus.src_cmd_ready       = '0;
        bus.src_tready          = '0;
        if (state == CMD) begin
            bus.eng_cmd_valid         = bus.src_cmd_valid[grant];
            bus.eng_cmd_csum_enable   = bus.src_cmd_csum_enable[grant];
            bus.eng_cmd_csum_start    = bus.src_cmd_csum_start[int'(grant)*8 +: 8];
            bus.eng_cmd_csum_offset   = bus.src_cmd_csum_offset[int'(grant)*8 +: 8];
            bus.eng_cmd_csum_init     = bus.src_cmd_csum_init[int'(grant)*16 +: 16];
            bus.src_cmd_ready[grant]  = bus.eng_cmd_ready;
        end else if (state == DATA) begin
            bus.eng_tdata             = bus.src_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            bus.eng_tkeep             = bus.src_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
            bus.eng_tvalid            = bus.src_tvalid[grant];
            bus.eng_tlast             = bus.src_tlast[grant];
            bus.src_tready[grant]     = bus.eng_tready;
        end
    end

    // Response routing runs off the FIFO head regardless of the request FSM.
    always_comb begin
        bus.dst_tdata       = '0;
        bus.dst_tkeep       = '0;
        bus.dst_tlast       = 1'b0;
        bus.dst_tvalid      = '0;
        bus.eng_resp_tready = 1'b0;
        if (!fifo_empty) begin
            bus.dst_tdata        = bus.eng_resp_tdata;
            bus.dst_tkeep        = bus.eng_resp_tkeep;
            bus.dst_tlast        = bus.eng_resp_tlast;
            bus.dst_tvalid[head] = bus.eng_resp_tvalid;
            bus.eng_resp_tready  = bus.dst_tready[head];
        end
    end

    assign push      = (state == CMD) && bus.eng_cmd_valid && bus.eng_cmd_ready;
    assign data_last = (state == DATA) && bus.eng_tvalid && bus.eng_tready && bus.eng_tlast;
    assign pop       = !fifo_empty && bus.eng_resp_tvalid && bus.eng_resp_tready && bus.eng_resp_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Fullness is only checked here; a granted packet always runs to tlast.
                    if (!fifo_full && pick_vld) begin
                        grant <= pick;
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (push) state <= DATA;
                end
                DATA: begin
                    if (data_last) begin
                        rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

`ifdef CSUM_ARB_STATS_EN
    logic [15:0] pkt_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) pkt_cnt[i] <= '0;
        end else if (data_last) begin
            pkt_cnt[grant] <= pkt_cnt[grant] + 16'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
        assign stat_pkt_count[gi*16 +: 16] = pkt_cnt[gi];
    end
`endif
endmodule

// File: tb/tb_checksum_engine_arbiter.sv
// Directed bench for checksum_engine_arbiter: a table of packet grants with hand-computed winners and
// cycle counts, plus hand sequences for reset, FIFO-full blocking and reset in the middle of a packet.
// Ports: none (drives the interface directly and plays requesters, engine and destinations).
module tb_checksum_engine_arbiter;
    localparam int NR = 2;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    checksum_engine_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) ifc ();

`ifdef CSUM_ARB_STATS_EN
    logic [16*NR-1:0] stat_pkt_count;
`endif

    checksum_engine_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.master)
`ifdef CSUM_ARB_STATS_EN
        ,
        .stat_pkt_count(stat_pkt_count)
`endif
    );

    typedef struct {
        logic [1:0] mask;    // requesters presenting a command
        int         nbeats;  // packet length in beats
        bit         toggle;  // eng_tready alternates 0/1 during data
        int         grant;   // expected winner
        int         cycles;  // expected cycles from cmd presented to last beat accepted
        bit         drain;   // return all outstanding responses afterwards
    } vec_t;

    vec_t tbl [13];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt [NR];
    int   owners [$];
    int   resp_n = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int vid, input int req, input int beat);
        return {8'hD0, 8'(vid), 8'(req), 8'(beat), 32'hC0DE_0000 + 32'(beat * 16 + req)};
    endfunction

    function automatic logic [63:0] rpat(input int n, input int b);
        return {32'h5E5E_0000 + 32'(n), 32'(b)};
    endfunction

    task automatic check_stats(input string name);
`ifdef CSUM_ARB_STATS_EN
        for (int i = 0; i < NR; i++)
            check(name, 64'(stat_pkt_count[i*16 +: 16]), 64'(exp_cnt[i] % 65536));
`endif
    endtask

    task automatic drive_cmds(input logic [1:0] mask, input int vid);
        ifc.src_cmd_valid = mask;
        for (int i = 0; i < NR; i++) begin
            ifc.src_cmd_csum_enable[i]           = 1'b1;
            ifc.src_cmd_csum_start[i*8 +: 8]     = 8'(14 + i);
            ifc.src_cmd_csum_offset[i*8 +: 8]    = 8'(26 + 4 * i);
            ifc.src_cmd_csum_init[i*16 +: 16]    = {8'(vid), 8'(i)};
        end
    endtask

    task automatic run_vec(input vec_t v, input int vid);
        int   cyc;
        int   beats;
        int   d;
        int   g;
        bit   got;
        logic [1:0] exp_rdy;
        g = v.grant;
        @(negedge clk);
        ifc.src_tvalid    = '0;
        ifc.eng_cmd_ready = 1'b1;
        ifc.eng_tready    = 1'b1;
        drive_cmds(v.mask, vid);
        cyc = 1;
        got = 1'b0;
        #1;
        for (int w = 0; w < 20 && !got; w++) begin
            if (ifc.eng_cmd_valid) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
                #1;
            end
        end
        check($sformatf("v%0d_cmd_seen", vid), 64'(got), 64'd1);
        if (!got) return;
        exp_rdy    = '0;
        exp_rdy[g] = 1'b1;
        check($sformatf("v%0d_cmd_ready", vid), 64'(ifc.src_cmd_ready), 64'(exp_rdy));
        check($sformatf("v%0d_cmd_offset", vid), 64'(ifc.eng_cmd_csum_offset), 64'(26 + 4 * g));
        check($sformatf("v%0d_cmd_start", vid), 64'(ifc.eng_cmd_csum_start), 64'(14 + g));
        check($sformatf("v%0d_cmd_init", vid), 64'(ifc.eng_cmd_csum_init), 64'({8'(vid), 8'(g)}));
        check($sformatf("v%0d_cmd_en", vid), 64'(ifc.eng_cmd_csum_enable), 64'd1);
        check($sformatf("v%0d_cmd_no_data", vid), 64'(ifc.eng_tvalid), 64'd0);

        beats = 0;
        d     = 0;
        while (beats < v.nbeats && d < 200) begin
            @(negedge clk);
            cyc++;
            ifc.src_cmd_valid = '0;
            for (int i = 0; i < NR; i++) begin
                if (v.mask[i]) begin
                    int b;
                    b = (i == g) ? beats : 0;
                    ifc.src_tvalid[i]         = 1'b1;
                    ifc.src_tdata[i*DW +: DW] = pat(vid, i, b);
                    ifc.src_tkeep[i*KW +: KW] = (b == v.nbeats - 1) ? 8'h0F : 8'hFF;
                    ifc.src_tlast[i]          = (b == v.nbeats - 1);
                end else begin
                    ifc.src_tvalid[i] = 1'b0;
                end
            end
            ifc.eng_tready = v.toggle ? ((d % 2) == 1) : 1'b1;
            #1;
            exp_rdy    = '0;
            exp_rdy[g] = ifc.eng_tready;
            check($sformatf("v%0d_src_tready", vid), 64'(ifc.src_tready), 64'(exp_rdy));
            if (ifc.eng_tvalid && ifc.eng_tready) begin
                check($sformatf("v%0d_b%0d_data", vid, beats), ifc.eng_tdata, pat(vid, g, beats));
                check($sformatf("v%0d_b%0d_keep", vid, beats), 64'(ifc.eng_tkeep),
                      (beats == v.nbeats - 1) ? 64'h0F : 64'hFF);
                check($sformatf("v%0d_b%0d_last", vid, beats), 64'(ifc.eng_tlast),
                      64'(beats == v.nbeats - 1));
                beats++;
            end
            d++;
        end
        check($sformatf("v%0d_beats", vid), 64'(beats), 64'(v.nbeats));
        check($sformatf("v%0d_cycles", vid), 64'(cyc), 64'(v.cycles));
        exp_cnt[g]++;
        owners.push_back(g);
    endtask

    task automatic drain();
        logic [1:0] exp_v;
        while (owners.size() > 0) begin
            int o;
            o = owners.pop_front();
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                ifc.src_tvalid      = '0;
                ifc.eng_resp_tvalid = 1'b1;
                ifc.eng_resp_tdata  = rpat(resp_n, b);
                ifc.eng_resp_tkeep  = 8'(8'hF0 | b);
                ifc.eng_resp_tlast  = (b == 1);
                ifc.dst_tready      = '1;
                #1;
                exp_v    = '0;
                exp_v[o] = 1'b1;
                check($sformatf("r%0d_dst_tvalid", resp_n), 64'(ifc.dst_tvalid), 64'(exp_v));
                check($sformatf("r%0d_resp_tready", resp_n), 64'(ifc.eng_resp_tready), 64'd1);
                check($sformatf("r%0d_dst_tdata", resp_n), ifc.dst_tdata, rpat(resp_n, b));
                check($sformatf("r%0d_dst_tlast", resp_n), 64'(ifc.dst_tlast), 64'(b == 1));
            end
            resp_n++;
        end
        // Extra response beat with nothing outstanding must find the FIFO empty.
        @(negedge clk);
        ifc.eng_resp_tvalid = 1'b1;
        ifc.eng_resp_tlast  = 1'b1;
        #1;
        check("drain_empty_dst_tvalid", 64'(ifc.dst_tvalid), 64'd0);
        check("drain_empty_resp_tready", 64'(ifc.eng_resp_tready), 64'd0);
        ifc.eng_resp_tvalid = 1'b0;
        ifc.eng_resp_tlast  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_eng_cmd_valid"}, 64'(ifc.eng_cmd_valid), 64'd0);
        check({tag, "_eng_tvalid"}, 64'(ifc.eng_tvalid), 64'd0);
        check({tag, "_src_cmd_ready"}, 64'(ifc.src_cmd_ready), 64'd0);
        check({tag, "_src_tready"}, 64'(ifc.src_tready), 64'd0);
        check({tag, "_dst_tvalid"}, 64'(ifc.dst_tvalid), 64'd0);
        check({tag, "_resp_tready"}, 64'(ifc.eng_resp_tready), 64'd0);
        check({tag, "_eng_tdata"}, ifc.eng_tdata, 64'd0);
        check({tag, "_dst_tdata"}, ifc.dst_tdata, 64'd0);
    endtask

    initial begin
        //            mask   beats tog grant cyc drain
        tbl[0]  = '{2'b01, 6, 1'b0, 0,  8, 1'b1};  // lone requester, offset 26
        tbl[1]  = '{2'b11, 3, 1'b0, 1,  5, 1'b0};  // rr alternates
        tbl[2]  = '{2'b11, 2, 1'b0, 0,  4, 1'b0};
        tbl[3]  = '{2'b11, 4, 1'b0, 1,  6, 1'b1};
        tbl[4]  = '{2'b10, 5, 1'b1, 1, 12, 1'b1};  // tready 0/1: beats at data cycles 1,3,5,7,9
        tbl[5]  = '{2'b10, 1, 1'b0, 1,  3, 1'b0};  // back-to-back single-beat
        tbl[6]  = '{2'b10, 1, 1'b0, 1,  3, 1'b1};
        tbl[7]  = '{2'b01, 2, 1'b0, 0,  4, 1'b0};  // fill the tag FIFO: 0,1,0,1
        tbl[8]  = '{2'b10, 1, 1'b0, 1,  3, 1'b0};
        tbl[9]  = '{2'b11, 1, 1'b0, 0,  3, 1'b0};
        tbl[10] = '{2'b11, 1, 1'b0, 1,  3, 1'b0};
        tbl[11] = '{2'b11, 2, 1'b0, 0,  4, 1'b1};  // after mid-packet reset rr is back at 0
        tbl[12] = '{2'b11, 1, 1'b0, 1,  3, 1'b1};
        for (int i = 0; i < NR; i++) exp_cnt[i] = 0;

        rst                 = 1'b1;
        ifc.src_cmd_valid   = 2'b11;
        ifc.src_cmd_csum_enable = '0;
        ifc.src_cmd_csum_start  = '0;
        ifc.src_cmd_csum_offset = '0;
        ifc.src_cmd_csum_init   = '0;
        ifc.src_tdata       = '0;
        ifc.src_tkeep       = '0;
        ifc.src_tvalid      = 2'b11;
        ifc.src_tlast       = '0;
        ifc.eng_cmd_ready   = 1'b1;
        ifc.eng_tready      = 1'b1;
        ifc.eng_resp_tdata  = 64'hFFFF_0000_FFFF_0000;
        ifc.eng_resp_tkeep  = '1;
        ifc.eng_resp_tvalid = 1'b1;
        ifc.eng_resp_tlast  = 1'b1;
        ifc.dst_tready      = '1;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        check_stats("reset_stats");
        @(negedge clk);
        rst                 = 1'b0;
        ifc.src_cmd_valid   = '0;
        ifc.src_tvalid      = '0;
        ifc.eng_resp_tvalid = 1'b0;
        ifc.eng_resp_tlast  = 1'b0;

        for (int v = 0; v <= 10; v++) begin
            run_vec(tbl[v], v);
            if (tbl[v].drain) drain();
        end

        // Four packets outstanding: a fifth command must wait while responses are stalled.
        @(negedge clk);
        ifc.src_tvalid      = '0;
        drive_cmds(2'b11, 15);
        ifc.dst_tready      = '0;
        ifc.eng_resp_tvalid = 1'b1;
        ifc.eng_resp_tlast  = 1'b1;
        ifc.eng_resp_tdata  = rpat(resp_n, 0);
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("full_c%0d_cmd_valid", c), 64'(ifc.eng_cmd_valid), 64'd0);
            check($sformatf("full_c%0d_cmd_ready", c), 64'(ifc.src_cmd_ready), 64'd0);
            @(negedge clk);
        end
        #1;
        check("full_head_dst_tvalid", 64'(ifc.dst_tvalid), 64'b01);
        check("full_head_resp_tready", 64'(ifc.eng_resp_tready), 64'd0);
        @(negedge clk);
        ifc.src_cmd_valid   = '0;
        ifc.eng_resp_tvalid = 1'b0;
        ifc.eng_resp_tlast  = 1'b0;
        drain();
        check_stats("stats_mid");

        // Reset while beat 3 of a req0 packet is on the bus.
        @(negedge clk);
        drive_cmds(2'b01, 20);
        @(negedge clk);
        #1;
        check("rstmid_cmd_valid", 64'(ifc.eng_cmd_valid), 64'd1);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            ifc.src_cmd_valid      = '0;
            ifc.src_tvalid         = 2'b01;
            ifc.src_tdata[0 +: DW] = pat(20, 0, b);
            ifc.src_tkeep[0 +: KW] = 8'hFF;
            ifc.src_tlast          = '0;
            if (b == 2) rst = 1'b1;
        end
        #1;
        check("rstmid_in_data", 64'(ifc.eng_tvalid), 64'd1);
        @(negedge clk);
        ifc.eng_resp_tvalid = 1'b1;
        ifc.eng_resp_tlast  = 1'b1;
        ifc.dst_tready      = '1;
        #1;
        check_idle_outputs("rstmid");
        for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
        check_stats("rstmid_stats");
        @(negedge clk);
        rst                 = 1'b0;
        ifc.src_tvalid      = '0;
        ifc.eng_resp_tvalid = 1'b0;
        ifc.eng_resp_tlast  = 1'b0;

        for (int v = 11; v <= 12; v++) begin
            run_vec(tbl[v], v);
            if (tbl[v].drain) drain();
        end
        check_stats("stats_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
